// File: rtl/axi4_lite_arbiter_if.sv
// AXI4-Lite bundle used on both sides of axi4_lite_arbiter.
// The master modport initiates requests; the slave modport answers them.
interface axi4_lite_arbiter_if #(
    parameter int ID_WIDTH   = 1,
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic [ID_WIDTH-1:0]   awid;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [2:0]            awprot;
    logic                  awvalid;
    logic                  awready;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic                  wvalid;
    logic                  wready;
    logic [ID_WIDTH-1:0]   bid;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    logic [ID_WIDTH-1:0]   arid;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [2:0]            arprot;
    logic                  arvalid;
    logic                  arready;
    logic [ID_WIDTH-1:0]   rid;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awid, awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output arid, araddr, arprot, arvalid, rready,
        input  awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rvalid
    );

    modport slave (
        input  awid, awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  arid, araddr, arprot, arvalid, rready,
        output awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi4_lite_arbiter.sv
// Two-port AXI4-Lite arbiter: independent write/read arbitration, ID tagging, response routing.
// Define AXI4_LITE_ARB_FIXED_PRIO_EN for fixed priority (port 0 wins ties) instead of round-robin.
module axi4_lite_arbiter #(
    parameter int AXI_ID_WIDTH   = 1,
    parameter int AXI_ADDR_WIDTH = 12,
    parameter int AXI_DATA_WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    axi4_lite_arbiter_if.slave  s0,
    axi4_lite_arbiter_if.slave  s1,
    axi4_lite_arbiter_if.master m
);
    localparam int AXI_BYTE_COUNT = AXI_DATA_WIDTH / 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t r_wr_state;
    state_t w_wr_state_nxt;
    state_t r_rd_state;
    state_t w_rd_state_nxt;
    logic   r_wr_grant;
    logic   r_rd_grant;
    logic   w_wr_sel;
    logic   w_rd_sel;
    logic   w_wr_pref;
    logic   w_rd_pref;
    logic   w_wr_fwd;
    logic   w_rd_fwd;
    logic [1:0] w_wr_elig;
    logic [1:0] w_rd_elig;
    logic [AXI_BYTE_COUNT-1:0] w_wr_strb;

    assign w_wr_elig = {s1.awvalid & s1.wvalid, s0.awvalid & s0.wvalid};
    assign w_rd_elig = {s1.arvalid, s0.arvalid};

`ifdef AXI4_LITE_ARB_FIXED_PRIO_EN
    assign w_wr_pref = 1'b0;
    assign w_rd_pref = 1'b0;
`else
    logic r_wr_ptr;
    logic r_rd_ptr;

    assign w_wr_pref = r_wr_ptr;
    assign w_rd_pref = r_rd_ptr;

    // Round-robin pointers move to the other port after each completed handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
        end else begin
            if (w_wr_fwd && m.awready) begin
                r_wr_ptr <= ~w_wr_sel;
            end else begin
                r_wr_ptr <= r_wr_ptr;
            end
            if (w_rd_fwd && m.arready) begin
                r_rd_ptr <= ~w_rd_sel;
            end else begin
                r_rd_ptr <= r_rd_ptr;
            end
        end
    end
`endif

    // State and grant registers; the grant tracks the live selection, so it is frozen while holding.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_state <= ST_IDLE;
            r_rd_state <= ST_IDLE;
            r_wr_grant <= 1'b0;
            r_rd_grant <= 1'b0;
        end else begin
            r_wr_state <= w_wr_state_nxt;
            r_rd_state <= w_rd_state_nxt;
            r_wr_grant <= w_wr_sel;
            r_rd_grant <= w_rd_sel;
        end
    end

    // Write path: grant selection and next state.
    always_comb begin
        w_wr_sel       = 1'b0;
        w_wr_state_nxt = r_wr_state;
        case (r_wr_state)
            ST_IDLE: begin
                if (w_wr_elig == 2'b11) begin
                    w_wr_sel = w_wr_pref;
                end else if (w_wr_elig[1]) begin
                    w_wr_sel = 1'b1;
                end else begin
                    w_wr_sel = 1'b0;
                end
                if (w_wr_fwd && !m.awready) begin
                    w_wr_state_nxt = ST_HOLD;
                end else begin
                    w_wr_state_nxt = ST_IDLE;
                end
            end
            ST_HOLD: begin
                w_wr_sel = r_wr_grant;
                if (w_wr_fwd && m.awready) begin
                    w_wr_state_nxt = ST_IDLE;
                end else begin
                    w_wr_state_nxt = ST_HOLD;
                end
            end
            default: begin
                w_wr_sel       = 1'b0;
                w_wr_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Read path: grant selection and next state.
    always_comb begin
        w_rd_sel       = 1'b0;
        w_rd_state_nxt = r_rd_state;
        case (r_rd_state)
            ST_IDLE: begin
                if (w_rd_elig == 2'b11) begin
                    w_rd_sel = w_rd_pref;
                end else if (w_rd_elig[1]) begin
                    w_rd_sel = 1'b1;
                end else begin
                    w_rd_sel = 1'b0;
                end
                if (w_rd_fwd && !m.arready) begin
                    w_rd_state_nxt = ST_HOLD;
                end else begin
                    w_rd_state_nxt = ST_IDLE;
                end
            end
            ST_HOLD: begin
                w_rd_sel = r_rd_grant;
                if (w_rd_fwd && m.arready) begin
                    w_rd_state_nxt = ST_IDLE;
                end else begin
                    w_rd_state_nxt = ST_HOLD;
                end
            end
            default: begin
                w_rd_sel       = 1'b0;
                w_rd_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Reset forces every downstream valid and upstream ready low.
    assign w_wr_fwd = ~reset & (w_wr_sel ? w_wr_elig[1] : w_wr_elig[0]);
    assign w_rd_fwd = ~reset & (w_rd_sel ? w_rd_elig[1] : w_rd_elig[0]);

    assign w_wr_strb = w_wr_sel ? s1.wstrb : s0.wstrb;

    assign m.awid    = {w_wr_sel, (w_wr_sel ? s1.awid : s0.awid)};
    assign m.awaddr  = w_wr_sel ? s1.awaddr : s0.awaddr;
    assign m.awprot  = w_wr_sel ? s1.awprot : s0.awprot;
    assign m.awvalid = w_wr_fwd;
    assign m.wdata   = w_wr_sel ? s1.wdata : s0.wdata;
    assign m.wstrb   = w_wr_strb;
    assign m.wvalid  = w_wr_fwd;

    assign s0.awready = w_wr_fwd & ~w_wr_sel & m.awready;
    assign s0.wready  = w_wr_fwd & ~w_wr_sel & m.awready;
    assign s1.awready = w_wr_fwd &  w_wr_sel & m.awready;
    assign s1.wready  = w_wr_fwd &  w_wr_sel & m.awready;

    assign m.arid    = {w_rd_sel, (w_rd_sel ? s1.arid : s0.arid)};
    assign m.araddr  = w_rd_sel ? s1.araddr : s0.araddr;
    assign m.arprot  = w_rd_sel ? s1.arprot : s0.arprot;
    assign m.arvalid = w_rd_fwd;

    assign s0.arready = w_rd_fwd & ~w_rd_sel & m.arready;
    assign s1.arready = w_rd_fwd &  w_rd_sel & m.arready;

    // Responses are steered purely by the tag bit, so out-of-order returns route correctly.
    assign s0.bvalid = m.bvalid & ~m.bid[AXI_ID_WIDTH];
    assign s1.bvalid = m.bvalid &  m.bid[AXI_ID_WIDTH];
    assign s0.bid    = m.bid[AXI_ID_WIDTH-1:0];
    assign s1.bid    = m.bid[AXI_ID_WIDTH-1:0];
    assign s0.bresp  = m.bresp;
    assign s1.bresp  = m.bresp;
    assign m.bready  = m.bid[AXI_ID_WIDTH] ? s1.bready : s0.bready;

    assign s0.rvalid = m.rvalid & ~m.rid[AXI_ID_WIDTH];
    assign s1.rvalid = m.rvalid &  m.rid[AXI_ID_WIDTH];
    assign s0.rid    = m.rid[AXI_ID_WIDTH-1:0];
    assign s1.rid    = m.rid[AXI_ID_WIDTH-1:0];
    assign s0.rdata  = m.rdata;
    assign s1.rdata  = m.rdata;
    assign s0.rresp  = m.rresp;
    assign s1.rresp  = m.rresp;
    assign m.rready  = m.rid[AXI_ID_WIDTH] ? s1.rready : s0.rready;
endmodule

// File: tb/tb_axi4_lite_arbiter.sv
// Self-checking bench for axi4_lite_arbiter: directed scenarios plus a randomized run
// against a queue-free request/lock/preference model of the arbitration rules.
module tb_axi4_lite_arbiter;
    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

`ifdef AXI4_LITE_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    always #5 clk = ~clk;

    axi4_lite_arbiter_if #(.ID_WIDTH(1), .ADDR_WIDTH(12), .DATA_WIDTH(32)) s0_if ();
    axi4_lite_arbiter_if #(.ID_WIDTH(1), .ADDR_WIDTH(12), .DATA_WIDTH(32)) s1_if ();
    axi4_lite_arbiter_if #(.ID_WIDTH(2), .ADDR_WIDTH(12), .DATA_WIDTH(32)) m_if ();

    axi4_lite_arbiter #(.AXI_ID_WIDTH(1), .AXI_ADDR_WIDTH(12), .AXI_DATA_WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .s0    (s0_if),
        .s1    (s1_if),
        .m     (m_if)
    );

    // Request state kept by the bench for each upstream port.
    bit          wr_pend [2];
    logic        wr_id   [2];
    logic [11:0] wr_addr [2];
    logic [31:0] wr_data [2];
    logic [3:0]  wr_strb [2];
    logic [2:0]  wr_prot [2];
    bit          rd_pend [2];
    logic        rd_id   [2];
    logic [11:0] rd_addr [2];
    logic [2:0]  rd_prot [2];

    task automatic clear_model_reqs();
        for (int p = 0; p < 2; p++) begin
            wr_pend[p] = 1'b0; wr_id[p] = 1'b0; wr_addr[p] = 12'h000;
            wr_data[p] = 32'h0; wr_strb[p] = 4'h0; wr_prot[p] = 3'b000;
            rd_pend[p] = 1'b0; rd_id[p] = 1'b0; rd_addr[p] = 12'h000; rd_prot[p] = 3'b000;
        end
    endtask

    task automatic drive_ports();
        s0_if.awvalid = wr_pend[0]; s0_if.wvalid = wr_pend[0];
        s0_if.awid = wr_id[0]; s0_if.awaddr = wr_addr[0]; s0_if.awprot = wr_prot[0];
        s0_if.wdata = wr_data[0]; s0_if.wstrb = wr_strb[0];
        s0_if.arvalid = rd_pend[0]; s0_if.arid = rd_id[0]; s0_if.araddr = rd_addr[0]; s0_if.arprot = rd_prot[0];
        s1_if.awvalid = wr_pend[1]; s1_if.wvalid = wr_pend[1];
        s1_if.awid = wr_id[1]; s1_if.awaddr = wr_addr[1]; s1_if.awprot = wr_prot[1];
        s1_if.wdata = wr_data[1]; s1_if.wstrb = wr_strb[1];
        s1_if.arvalid = rd_pend[1]; s1_if.arid = rd_id[1]; s1_if.araddr = rd_addr[1]; s1_if.arprot = rd_prot[1];
    endtask

    task automatic idle_inputs();
        clear_model_reqs();
        drive_ports();
        s0_if.bready = 1'b1; s0_if.rready = 1'b1;
        s1_if.bready = 1'b1; s1_if.rready = 1'b1;
        m_if.awready = 1'b0; m_if.wready = 1'b0; m_if.arready = 1'b0;
        m_if.bvalid = 1'b0; m_if.bid = 2'b00; m_if.bresp = 2'b00;
        m_if.rvalid = 1'b0; m_if.rid = 2'b00; m_if.rdata = 32'h0; m_if.rresp = 2'b00;
    endtask

    // Leaves time at posedge+1 with reset low and both paths freshly reset.
    task automatic apply_reset();
        reset = 1'b1;
        idle_inputs();
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        wr_pend[0] = 1'b1; rd_pend[1] = 1'b1;
        drive_ports();
        m_if.awready = 1'b1; m_if.arready = 1'b1;
        m_if.bvalid = 1'b1; m_if.bid = 2'b10; m_if.rvalid = 1'b1; m_if.rid = 2'b00;
        #4;
        checks++; if (m_if.awvalid !== 1'b0) begin errors++; $display("FAIL reset_awvalid got=%b exp=0", m_if.awvalid); end
        checks++; if (m_if.wvalid !== 1'b0) begin errors++; $display("FAIL reset_wvalid got=%b exp=0", m_if.wvalid); end
        checks++; if (m_if.arvalid !== 1'b0) begin errors++; $display("FAIL reset_arvalid got=%b exp=0", m_if.arvalid); end
        checks++; if (s0_if.awready !== 1'b0) begin errors++; $display("FAIL reset_s0_awready got=%b exp=0", s0_if.awready); end
        checks++; if (s1_if.arready !== 1'b0) begin errors++; $display("FAIL reset_s1_arready got=%b exp=0", s1_if.arready); end
        checks++; if ({s1_if.bvalid, s0_if.bvalid} !== 2'b10) begin errors++; $display("FAIL reset_bvalid_route got=%b exp=10", {s1_if.bvalid, s0_if.bvalid}); end
        checks++; if ({s1_if.rvalid, s0_if.rvalid} !== 2'b01) begin errors++; $display("FAIL reset_rvalid_route got=%b exp=01", {s1_if.rvalid, s0_if.rvalid}); end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_single_write();
        apply_reset();
        wr_pend[0] = 1'b1; wr_id[0] = 1'b0; wr_addr[0] = 12'h010; wr_data[0] = 32'hDEADBEEF; wr_strb[0] = 4'hF;
        drive_ports();
        m_if.awready = 1'b1;
        #4;
        checks++; if (m_if.awvalid !== 1'b1 || m_if.wvalid !== 1'b1) begin errors++; $display("FAIL single_valid got=%b%b exp=11", m_if.awvalid, m_if.wvalid); end
        checks++; if (m_if.awaddr !== 12'h010) begin errors++; $display("FAIL single_awaddr got=%h exp=010", m_if.awaddr); end
        checks++; if (m_if.awid !== 2'b00) begin errors++; $display("FAIL single_awid got=%b exp=00", m_if.awid); end
        checks++; if (m_if.wdata !== 32'hDEADBEEF || m_if.wstrb !== 4'hF) begin errors++; $display("FAIL single_wdata got=%h/%h exp=deadbeef/f", m_if.wdata, m_if.wstrb); end
        checks++; if ({s1_if.awready, s0_if.awready, s0_if.wready} !== 3'b011) begin errors++; $display("FAIL single_ready got=%b exp=011", {s1_if.awready, s0_if.awready, s0_if.wready}); end
        @(posedge clk); #1;
        wr_pend[0] = 1'b0;
        drive_ports();
        m_if.bvalid = 1'b1; m_if.bid = 2'b00; m_if.bresp = 2'b00;
        #4;
        checks++; if (m_if.awvalid !== 1'b0) begin errors++; $display("FAIL single_after_awvalid got=%b exp=0", m_if.awvalid); end
        checks++; if (s0_if.bvalid !== 1'b1 || s0_if.bid !== 1'b0) begin errors++; $display("FAIL single_b_s0 got=%b/%b exp=1/0", s0_if.bvalid, s0_if.bid); end
        checks++; if (s1_if.bvalid !== 1'b0) begin errors++; $display("FAIL single_b_s1 got=%b exp=0", s1_if.bvalid); end
        @(posedge clk); #1;
        m_if.bvalid = 1'b0;
    endtask

    task automatic test_contention();
        logic exp_port;
        apply_reset();
        for (int p = 0; p < 2; p++) begin
            wr_pend[p] = 1'b1; wr_id[p] = 1'(p); wr_addr[p] = 12'h100 + 12'(p); wr_data[p] = 32'hA0 + 32'(p); wr_strb[p] = 4'hF;
        end
        drive_ports();
        m_if.awready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            if (c == 4) begin
                wr_pend[0] = 1'b0;
                drive_ports();
            end
            exp_port = (c == 4) ? 1'b1 : (FIXED ? 1'b0 : 1'(c % 2));
            #4;
            checks++; if (m_if.awvalid !== 1'b1 || m_if.awid[1] !== exp_port) begin errors++; $display("FAIL contention_grant c=%0d got=%b/%b exp=1/%b", c, m_if.awvalid, m_if.awid[1], exp_port); end
            @(posedge clk); #1;
        end
        wr_pend[1] = 1'b0;
        drive_ports();
    endtask

    task automatic test_backpressure();
        apply_reset();
        rd_pend[1] = 1'b1; rd_id[1] = 1'b0; rd_addr[1] = 12'h020;
        drive_ports();
        for (int c = 0; c < 4; c++) begin
            if (c == 2) begin
                rd_pend[0] = 1'b1; rd_id[0] = 1'b1; rd_addr[0] = 12'h030;
                drive_ports();
            end
            m_if.arready = (c == 3) ? 1'b1 : 1'b0;
            #4;
            checks++; if (m_if.arvalid !== 1'b1 || m_if.arid !== 2'b10 || m_if.araddr !== 12'h020) begin errors++; $display("FAIL bp_hold c=%0d got=%b/%b/%h exp=1/10/020", c, m_if.arvalid, m_if.arid, m_if.araddr); end
            checks++; if (s1_if.arready !== m_if.arready || s0_if.arready !== 1'b0) begin errors++; $display("FAIL bp_ready c=%0d got=%b%b exp=%b0", c, s1_if.arready, s0_if.arready, m_if.arready); end
            @(posedge clk); #1;
        end
        rd_pend[1] = 1'b0;
        drive_ports();
        #4;
        checks++; if (m_if.arvalid !== 1'b1 || m_if.arid !== 2'b01 || m_if.araddr !== 12'h030 || s0_if.arready !== 1'b1) begin errors++; $display("FAIL bp_next got=%b/%b/%h/%b exp=1/01/030/1", m_if.arvalid, m_if.arid, m_if.araddr, s0_if.arready); end
        @(posedge clk); #1;
        rd_pend[0] = 1'b0;
        drive_ports();
        m_if.arready = 1'b0;
    endtask

    task automatic test_concurrent();
        apply_reset();
        wr_pend[0] = 1'b1; wr_addr[0] = 12'h044; wr_data[0] = 32'h55; wr_strb[0] = 4'h3;
        rd_pend[1] = 1'b1; rd_addr[1] = 12'h088;
        drive_ports();
        m_if.awready = 1'b1; m_if.arready = 1'b1;
        #4;
        checks++; if (m_if.awvalid !== 1'b1 || m_if.awid !== 2'b00 || m_if.awaddr !== 12'h044) begin errors++; $display("FAIL conc_write got=%b/%b/%h exp=1/00/044", m_if.awvalid, m_if.awid, m_if.awaddr); end
        checks++; if (m_if.arvalid !== 1'b1 || m_if.arid !== 2'b10 || m_if.araddr !== 12'h088) begin errors++; $display("FAIL conc_read got=%b/%b/%h exp=1/10/088", m_if.arvalid, m_if.arid, m_if.araddr); end
        @(posedge clk); #1;
        clear_model_reqs();
        drive_ports();
        s0_if.bready = 1'b1; s1_if.bready = 1'b0; s0_if.rready = 1'b0; s1_if.rready = 1'b1;
        m_if.bvalid = 1'b1; m_if.bid = 2'b00; m_if.bresp = 2'b10;
        m_if.rvalid = 1'b1; m_if.rid = 2'b10; m_if.rdata = 32'h12345678; m_if.rresp = 2'b01;
        #4;
        checks++; if ({s1_if.bvalid, s0_if.bvalid} !== 2'b01 || s0_if.bresp !== 2'b10 || m_if.bready !== 1'b1) begin errors++; $display("FAIL conc_b got=%b/%b/%b exp=01/10/1", {s1_if.bvalid, s0_if.bvalid}, s0_if.bresp, m_if.bready); end
        checks++; if ({s1_if.rvalid, s0_if.rvalid} !== 2'b10 || s1_if.rdata !== 32'h12345678 || s1_if.rresp !== 2'b01 || s1_if.rid !== 1'b0) begin errors++; $display("FAIL conc_r got=%b/%h/%b exp=10/12345678/01", {s1_if.rvalid, s0_if.rvalid}, s1_if.rdata, s1_if.rresp); end
        checks++; if (m_if.rready !== 1'b1) begin errors++; $display("FAIL conc_rready got=%b exp=1", m_if.rready); end
        @(posedge clk); #1;
        idle_inputs();
    endtask

    task automatic test_reset_in_hold();
        apply_reset();
        wr_pend[1] = 1'b1; wr_id[1] = 1'b1; wr_addr[1] = 12'h0F0;
        drive_ports();
        m_if.awready = 1'b0;
        @(posedge clk); #1;
        wr_pend[0] = 1'b1; wr_id[0] = 1'b0; wr_addr[0] = 12'h00F;
        drive_ports();
        #4;
        checks++; if (m_if.awvalid !== 1'b1 || m_if.awid !== 2'b11 || m_if.awaddr !== 12'h0F0) begin errors++; $display("FAIL hold_s1 got=%b/%b/%h exp=1/11/0f0", m_if.awvalid, m_if.awid, m_if.awaddr); end
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        #4;
        checks++; if (m_if.awvalid !== 1'b0 || m_if.wvalid !== 1'b0 || m_if.arvalid !== 1'b0) begin errors++; $display("FAIL hold_reset_valids got=%b%b%b exp=000", m_if.awvalid, m_if.wvalid, m_if.arvalid); end
        @(posedge clk); #1;
        reset = 1'b0;
        m_if.awready = 1'b1;
        #4;
        checks++; if (m_if.awvalid !== 1'b1 || m_if.awid !== 2'b00 || m_if.awaddr !== 12'h00F) begin errors++; $display("FAIL hold_after_reset_tie got=%b/%b/%h exp=1/00/00f", m_if.awvalid, m_if.awid, m_if.awaddr); end
        @(posedge clk); #1;
        idle_inputs();
    endtask

    // Arbitration rules: a locked port keeps the path; otherwise a tie goes to the preferred port.
    function automatic int pick_winner(input bit e0, input bit e1, input int locked, input int pref);
        if (locked >= 0) return locked;
        if (e0 && e1) return FIXED ? 0 : pref;
        if (e0) return 0;
        if (e1) return 1;
        return -1;
    endfunction

    task automatic test_random();
        int wl, wp, rl, rp, ww, rw;
        bit awr, arr, e_b, e_r;
        logic [1:0] e_id, tag;
        logic [31:0] e_rdata;
        apply_reset();
        wl = -1; wp = 0; rl = -1; rp = 0;
        for (int c = 0; c < 400; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (!wr_pend[p] && ($urandom_range(0, 1) == 1)) begin
                    wr_pend[p] = 1'b1; wr_id[p] = 1'($urandom); wr_addr[p] = 12'($urandom);
                    wr_data[p] = $urandom; wr_strb[p] = 4'($urandom); wr_prot[p] = 3'($urandom);
                end
                if (!rd_pend[p] && ($urandom_range(0, 1) == 1)) begin
                    rd_pend[p] = 1'b1; rd_id[p] = 1'($urandom); rd_addr[p] = 12'($urandom); rd_prot[p] = 3'($urandom);
                end
            end
            drive_ports();
            awr = 1'($urandom); arr = 1'($urandom);
            m_if.awready = awr; m_if.arready = arr;
            e_b = 1'($urandom); tag = 2'($urandom);
            m_if.bvalid = e_b; m_if.bid = tag; m_if.bresp = 2'($urandom);
            s0_if.bready = 1'($urandom); s1_if.bready = 1'($urandom);
            e_r = 1'($urandom); e_rdata = $urandom;
            m_if.rvalid = e_r; m_if.rid = ~tag; m_if.rdata = e_rdata; m_if.rresp = 2'($urandom);
            s0_if.rready = 1'($urandom); s1_if.rready = 1'($urandom);
            ww = pick_winner(wr_pend[0], wr_pend[1], wl, wp);
            rw = pick_winner(rd_pend[0], rd_pend[1], rl, rp);
            #4;
            checks++; if (m_if.awvalid !== (ww >= 0) || m_if.wvalid !== (ww >= 0)) begin errors++; $display("FAIL rnd_awvalid c=%0d got=%b exp=%b", c, m_if.awvalid, (ww >= 0)); end
            if (ww >= 0) begin
                e_id = {1'(ww), wr_id[ww]};
                checks++; if (m_if.awid !== e_id || m_if.awaddr !== wr_addr[ww] || m_if.wdata !== wr_data[ww] || m_if.wstrb !== wr_strb[ww] || m_if.awprot !== wr_prot[ww]) begin
                    errors++; $display("FAIL rnd_aw c=%0d got=%b/%h/%h exp=%b/%h/%h", c, m_if.awid, m_if.awaddr, m_if.wdata, e_id, wr_addr[ww], wr_data[ww]); end
            end
            checks++; if ({s1_if.awready, s0_if.awready} !== {(ww == 1) && awr, (ww == 0) && awr}) begin errors++; $display("FAIL rnd_awready c=%0d got=%b%b win=%0d rdy=%b", c, s1_if.awready, s0_if.awready, ww, awr); end
            checks++; if (m_if.arvalid !== (rw >= 0)) begin errors++; $display("FAIL rnd_arvalid c=%0d got=%b exp=%b", c, m_if.arvalid, (rw >= 0)); end
            if (rw >= 0) begin
                e_id = {1'(rw), rd_id[rw]};
                checks++; if (m_if.arid !== e_id || m_if.araddr !== rd_addr[rw] || m_if.arprot !== rd_prot[rw]) begin errors++; $display("FAIL rnd_ar c=%0d got=%b/%h exp=%b/%h", c, m_if.arid, m_if.araddr, e_id, rd_addr[rw]); end
            end
            checks++; if ({s1_if.arready, s0_if.arready} !== {(rw == 1) && arr, (rw == 0) && arr}) begin errors++; $display("FAIL rnd_arready c=%0d got=%b%b win=%0d rdy=%b", c, s1_if.arready, s0_if.arready, rw, arr); end
            checks++; if ({s1_if.bvalid, s0_if.bvalid} !== {e_b && tag[1], e_b && !tag[1]} || s0_if.bid !== tag[0] || s1_if.bid !== tag[0] || m_if.bready !== (tag[1] ? s1_if.bready : s0_if.bready)) begin
                errors++; $display("FAIL rnd_b c=%0d got=%b/%b tag=%b", c, {s1_if.bvalid, s0_if.bvalid}, m_if.bready, tag); end
            checks++; if ({s1_if.rvalid, s0_if.rvalid} !== {e_r && !tag[1], e_r && tag[1]} || s0_if.rdata !== e_rdata || s1_if.rdata !== e_rdata || m_if.rready !== (tag[1] ? s0_if.rready : s1_if.rready)) begin
                errors++; $display("FAIL rnd_r c=%0d got=%b/%h/%b tag=%b", c, {s1_if.rvalid, s0_if.rvalid}, s1_if.rdata, m_if.rready, ~tag); end
            if (ww >= 0) begin
                if (awr) begin wr_pend[ww] = 1'b0; wl = -1; wp = 1 - ww; end
                else begin wl = ww; end
            end
            if (rw >= 0) begin
                if (arr) begin rd_pend[rw] = 1'b0; rl = -1; rp = 1 - rw; end
                else begin rl = rw; end
            end
            @(posedge clk); #1;
        end
        idle_inputs();
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        @(posedge clk); #1;
        test_reset();
        test_single_write();
        test_contention();
        test_backpressure();
        test_concurrent();
        test_reset_in_hold();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
